// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath select codes driven by the controller.
package core_ctrl_pkg;

    // state | meaning
    // FETCH    | read instruction at PC, PC <= PC + 4
    // DECODE   | read registers, precompute branch target
    // MEMADR   | compute load/store address
    // MEMREAD  | load data read, waits for mem_ready
    // MEMWB    | write loaded data to the register file
    // MEMWRITE | store data write, waits for mem_ready
    // EXECR    | register-register ALU operation
    // EXECI    | register-immediate ALU operation
    // ALUWB    | write ALU result to the register file
    // JAL      | PC <= target, link = OldPC + 4
    // BEQ      | compare, PC <= target when equal
    // ILLEGAL  | unknown opcode trap, left only by reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Unified instruction/data memory handshake between controller and memory.
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_next_state.sv
// Next-state logic for the multicycle controller; purely combinational.
module fsm_next_state
    import core_ctrl_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  state_t     i_state,
    input  logic [6:0] i_op,
    input  logic       i_mem_ready,
    output state_t     o_next_state
);

    // Transition table; undefined encodings fall back to FETCH.
    always_comb begin
        o_next_state = S_FETCH;
        case (i_state)
            S_FETCH:    o_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: o_next_state = S_MEMADR;
                    OP_RTYPE:          o_next_state = S_EXECR;
                    OP_ITYPE:          o_next_state = S_EXECI;
                    OP_BRANCH:         o_next_state = S_BEQ;
                    OP_JAL:            o_next_state = S_JAL;
                    default:           o_next_state = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   o_next_state = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  o_next_state = i_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    o_next_state = S_FETCH;
            S_MEMWRITE: o_next_state = i_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    o_next_state = S_ALUWB;
            S_EXECI:    o_next_state = S_ALUWB;
            S_ALUWB:    o_next_state = S_FETCH;
            S_JAL:      o_next_state = S_ALUWB;
            S_BEQ:      o_next_state = S_FETCH;
            S_ILLEGAL:  o_next_state = S_ILLEGAL;
            default:    o_next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RV32I core: state register plus
// per-state datapath select/enable decode. Only ir_write/pc_write in FETCH
// (mem_ready), pc_write in BEQ (zero) and imm_src in MEMADR (op) look past
// the current state.
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic       i_zero,
    multicycle_control_fsm_if.master m_mem,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_imm_src,
    output logic       o_reg_write,
    output logic       o_illegal_op,
    output logic [3:0] o_state_dbg
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;

    fsm_next_state #(
        .TRAP_ILLEGAL (TRAP_ILLEGAL)
    ) u_next_state (
        .i_state      (r_state),
        .i_op         (i_op),
        .i_mem_ready  (m_mem.mem_ready),
        .o_next_state (w_next_state)
    );

    // State register; reset returns to FETCH from any state, abandoning any access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output decode per state; everything not named in a state stays 0.
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        o_ir_write   = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        o_alu_op     = ALUOP_ADD;
        o_imm_src    = IMM_I;
        o_reg_write  = 1'b0;
        o_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_ir_write   = m_mem.mem_ready;
                w_pc_update  = m_mem.mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = IMM_B;
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                o_result_src = RES_ALUOUT;
                w_adr_src    = 1'b1;
                w_mem_req    = 1'b1;
            end
            S_MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_result_src = RES_ALUOUT;
                w_adr_src    = 1'b1;
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_RD2;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALUOP_FUNCT;
                o_imm_src   = IMM_I;
            end
            S_ALUWB: begin
                o_result_src = RES_ALUOUT;
                o_reg_write  = 1'b1;
            end
            S_JAL: begin
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALUOUT;
                w_pc_update  = 1'b1;
            end
            S_BEQ: begin
                o_alu_src_a  = SRCA_RD1;
                o_alu_src_b  = SRCB_RD2;
                o_alu_op     = ALUOP_SUB;
                o_result_src = RES_ALUOUT;
                w_branch     = 1'b1;
            end
            S_ILLEGAL: begin
                o_illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_pc_write      = w_pc_update | (w_branch & i_zero);
    assign m_mem.mem_req   = w_mem_req;
    assign m_mem.mem_write = w_mem_write;
    assign m_mem.adr_src   = w_adr_src;
    assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one trapping and one non-trapping
// instance run side by side on identical stimulus.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_dbg;

    logic       pc_write0, ir_write0, reg_write0, illegal_op0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0, imm_src0;
    logic [3:0] state_dbg0;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control_fsm_if bus1 ();
    multicycle_control_fsm_if bus0 ();
    assign bus1.mem_ready = mem_ready;
    assign bus0.mem_ready = mem_ready;

    multicycle_control_fsm #(.TRAP_ILLEGAL(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .m_mem(bus1),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_result_src(result_src),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_imm_src(imm_src), .o_reg_write(reg_write), .o_illegal_op(illegal_op),
        .o_state_dbg(state_dbg)
    );

    multicycle_control_fsm #(.TRAP_ILLEGAL(1'b0)) dut_nop (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .m_mem(bus0),
        .o_pc_write(pc_write0), .o_ir_write(ir_write0), .o_result_src(result_src0),
        .o_alu_src_a(alu_src_a0), .o_alu_src_b(alu_src_b0), .o_alu_op(alu_op0),
        .o_imm_src(imm_src0), .o_reg_write(reg_write0), .o_illegal_op(illegal_op0),
        .o_state_dbg(state_dbg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; op = 7'd0; zero = 1'b0;
        repeat (3) tick();
        n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        n_checks++; if (bus1.mem_req !== 1'b1) begin n_errors++; $display("FAIL reset_mem_req got %b want 1", bus1.mem_req); end
        n_checks++; if (ir_write !== 1'b1) begin n_errors++; $display("FAIL reset_ir_write got %b want 1", ir_write); end
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
        n_checks++; if (bus1.mem_write !== 1'b0) begin n_errors++; $display("FAIL reset_mem_write got %b want 0", bus1.mem_write); end
        mem_ready = 1'b0;
        #1;
        n_checks++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || bus1.adr_src !== 1'b0) begin
            n_errors++; $display("FAIL fetch_nready_enables got ir=%b pc=%b adr=%b want 0 0 0", ir_write, pc_write, bus1.adr_src); end
        rst = 1'b0;
        tick();
        n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL fetch_stall got %0d want 0", state_dbg); end
        mem_ready = 1'b1;
        #1;
        n_checks++; if (pc_write !== 1'b1 || ir_write !== 1'b1) begin
            n_errors++; $display("FAIL fetch_ready_enables got pc=%b ir=%b want 1 1", pc_write, ir_write); end
    endtask

    task automatic test_load();
        logic [3:0] exp_s [0:5];
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 7'b0000011; mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (state_dbg !== exp_s[i]) begin n_errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
            n_checks++; if (reg_write !== (exp_s[i] == 4'd4)) begin n_errors++; $display("FAIL lw_reg_write[%0d] got %b want %b", i, reg_write, exp_s[i] == 4'd4); end
            if (exp_s[i] == 4'd4) begin
                n_checks++; if (result_src !== 2'b01) begin n_errors++; $display("FAIL lw_result_src got %b want 01", result_src); end
            end
            if (exp_s[i] == 4'd3) begin
                n_checks++; if (bus1.adr_src !== 1'b1 || bus1.mem_req !== 1'b1 || bus1.mem_write !== 1'b0) begin
                    n_errors++; $display("FAIL lw_memread got adr=%b req=%b wr=%b want 1 1 0", bus1.adr_src, bus1.mem_req, bus1.mem_write); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_store_stall();
        op = 7'b0100011; mem_ready = 1'b1;
        #1;
        n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL sw_start got %0d want 0", state_dbg); end
        tick();
        n_checks++; if (state_dbg !== 4'd1) begin n_errors++; $display("FAIL sw_decode got %0d want 1", state_dbg); end
        n_checks++; if (imm_src !== 2'b10 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01) begin
            n_errors++; $display("FAIL decode_selects got imm=%b a=%b b=%b want 10 01 01", imm_src, alu_src_a, alu_src_b); end
        tick();
        n_checks++; if (state_dbg !== 4'd2) begin n_errors++; $display("FAIL sw_memadr got %0d want 2", state_dbg); end
        n_checks++; if (imm_src !== 2'b01 || alu_src_a !== 2'b10) begin
            n_errors++; $display("FAIL sw_memadr_sel got imm=%b a=%b want 01 10", imm_src, alu_src_a); end
        tick();
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            #1;
            n_checks++; if (state_dbg !== 4'd5) begin n_errors++; $display("FAIL sw_hold[%0d] got %0d want 5", k, state_dbg); end
            n_checks++; if (bus1.mem_write !== 1'b1 || bus1.mem_req !== 1'b1 || bus1.adr_src !== 1'b1) begin
                n_errors++; $display("FAIL sw_strobe[%0d] got wr=%b req=%b adr=%b want 1 1 1", k, bus1.mem_write, bus1.mem_req, bus1.adr_src); end
            tick();
        end
        n_checks++; if (state_dbg !== 4'd0 || bus1.mem_write !== 1'b0) begin
            n_errors++; $display("FAIL sw_done got state=%0d wr=%b want 0 0", state_dbg, bus1.mem_write); end
    endtask

    task automatic test_branch();
        logic zv;
        op = 7'b1100011; mem_ready = 1'b1;
        for (int z = 0; z < 2; z++) begin
            zv = (z == 0);
            zero = zv;
            #1;
            n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL beq_start z=%b got %0d want 0", zv, state_dbg); end
            tick();
            n_checks++; if (state_dbg !== 4'd1) begin n_errors++; $display("FAIL beq_decode z=%b got %0d want 1", zv, state_dbg); end
            tick();
            n_checks++; if (state_dbg !== 4'd10) begin n_errors++; $display("FAIL beq_state z=%b got %0d want 10", zv, state_dbg); end
            n_checks++; if (pc_write !== zv) begin n_errors++; $display("FAIL beq_pc_write got %b want %b", pc_write, zv); end
            n_checks++; if (alu_op !== 2'b01 || reg_write !== 1'b0) begin
                n_errors++; $display("FAIL beq_ctrl got alu_op=%b rw=%b want 01 0", alu_op, reg_write); end
            tick();
            n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL beq_done z=%b got %0d want 0", zv, state_dbg); end
        end
        zero = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [0:1];
        logic [3:0] mid [0:1];
        ops = '{7'b0010011, 7'b1101111};
        mid = '{4'd7, 4'd9};
        mem_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            op = ops[j];
            #1;
            tick();
            n_checks++; if (state_dbg !== 4'd1) begin n_errors++; $display("FAIL alu_decode[%0d] got %0d want 1", j, state_dbg); end
            tick();
            n_checks++; if (state_dbg !== mid[j]) begin n_errors++; $display("FAIL alu_exec[%0d] got %0d want %0d", j, state_dbg, mid[j]); end
            if (j == 0) begin
                n_checks++; if (alu_op !== 2'b10 || alu_src_b !== 2'b01 || pc_write !== 1'b0) begin
                    n_errors++; $display("FAIL execi_sel got op=%b b=%b pc=%b want 10 01 0", alu_op, alu_src_b, pc_write); end
            end else begin
                n_checks++; if (pc_write !== 1'b1 || reg_write !== 1'b0 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin
                    n_errors++; $display("FAIL jal_sel got pc=%b rw=%b a=%b b=%b want 1 0 01 10", pc_write, reg_write, alu_src_a, alu_src_b); end
            end
            tick();
            n_checks++; if (state_dbg !== 4'd8 || reg_write !== 1'b1 || pc_write !== 1'b0 || result_src !== 2'b00) begin
                n_errors++; $display("FAIL aluwb[%0d] got s=%0d rw=%b pc=%b res=%b want 8 1 0 00", j, state_dbg, reg_write, pc_write, result_src); end
            tick();
            n_checks++; if (state_dbg !== 4'd0) begin n_errors++; $display("FAIL alu_done[%0d] got %0d want 0", j, state_dbg); end
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111; mem_ready = 1'b1;
        #1;
        tick();
        n_checks++; if (state_dbg !== 4'd1 || state_dbg0 !== 4'd1) begin
            n_errors++; $display("FAIL ill_decode got %0d/%0d want 1/1", state_dbg, state_dbg0); end
        tick();
        n_checks++; if (state_dbg !== 4'd11 || illegal_op !== 1'b1) begin
            n_errors++; $display("FAIL ill_trap got s=%0d ill=%b want 11 1", state_dbg, illegal_op); end
        n_checks++; if (state_dbg0 !== 4'd0 || illegal_op0 !== 1'b0) begin
            n_errors++; $display("FAIL ill_nop got s=%0d ill=%b want 0 0", state_dbg0, illegal_op0); end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (state_dbg !== 4'd11 || illegal_op !== 1'b1 || bus1.mem_req !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin
                n_errors++; $display("FAIL ill_hold[%0d] got s=%0d ill=%b req=%b pc=%b rw=%b want 11 1 0 0 0", k, state_dbg, illegal_op, bus1.mem_req, pc_write, reg_write); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (state_dbg !== 4'd0 || illegal_op !== 1'b0 || state_dbg0 !== 4'd0) begin
            n_errors++; $display("FAIL ill_clear got s=%0d ill=%b s0=%0d want 0 0 0", state_dbg, illegal_op, state_dbg0); end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] exp_s [0:4];
        exp_s = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        op = 7'b0100011; mem_ready = 1'b1;
        #1;
        repeat (3) tick();
        mem_ready = 1'b0;
        #1;
        n_checks++; if (state_dbg !== 4'd5 || bus1.mem_write !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_pre got s=%0d wr=%b want 5 1", state_dbg, bus1.mem_write); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (state_dbg !== 4'd0 || bus1.mem_write !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_post got s=%0d wr=%b want 0 0", state_dbg, bus1.mem_write); end
        rst = 1'b0; op = 7'b0110011; mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (state_dbg !== exp_s[i]) begin n_errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
            if (exp_s[i] == 4'd6) begin
                n_checks++; if (alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
                    n_errors++; $display("FAIL execr_sel got op=%b a=%b b=%b want 10 10 00", alu_op, alu_src_a, alu_src_b); end
            end
            if (i < 4) tick();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_stall();
        test_branch();
        test_alu_ops();
        test_illegal();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
